// File: rtl/lsu_mem_master_pkg.sv
// Shared definitions for the load/store memory master: funct3 codes, FSM states
// and the request legality check.
package riscv_lsu_defs;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_MOD  = 3'd3,
    ST_WR   = 3'd4,
    ST_RESP = 3'd5
  } lsu_state_e;

  // Misalignment or a funct3 that is not legal for the access direction.
  function automatic logic encoding_err(input logic is_store, input logic [2:0] funct3,
                                        input logic [1:0] lane);
    logic bad;
    bad = 1'b1;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lane[0];
      F3_W:    bad = (lane != 2'b00);
      F3_BU:   bad = is_store;
      F3_HU:   bad = is_store | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Combinational lane logic: load byte/half extraction with extension, and
// sub-word merge of store data into a read word (little-endian lanes).
module lsu_lane_align
  import riscv_lsu_defs::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    byte_s    = 8'd0;
    half_s    = 16'd0;
    load_data = 32'd0;
    case (lane)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'd0;
    endcase
    if (lane[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'd0, byte_s};
      F3_HU:   load_data = {16'd0, half_s};
      default: load_data = 32'd0;
    endcase
  end

  // Store merge: only the addressed lane is replaced.
  always_comb begin
    merged = word;
    case (funct3)
      F3_B: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          2'd3:    merged[31:24] = wdata[7:0];
          default: merged        = word;
        endcase
      end
      F3_H: begin
        if (lane[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      F3_W:    merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a synchronous-read, word-write data memory.
// One request in flight; sub-word stores use read-modify-write.
module lsu_mem_master
  import riscv_lsu_defs::*;
#(
  parameter int MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  input  logic [31:0] mem_q
);

  localparam logic [29:0] DEPTH_W = 30'(MEM_DEPTH);

  lsu_state_e  state_r, next_state_s;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        mem_we_r;
  logic        accept_s;
  logic        err_s;
  logic [31:0] load_s;
  logic [31:0] merged_s;
  logic [31:0] word_idx_s;

  assign req_ready = (state_r == ST_IDLE) & rst_n;
  assign accept_s  = req_valid & req_ready;
  assign err_s     = encoding_err(req_we, req_funct3, req_addr[1:0]) |
                     (req_addr[31:2] >= DEPTH_W);
  // A reset landing mid-write must never reach memory.
  assign mem_we    = mem_we_r & rst_n;

  lsu_lane_align u_align (
    .word      (mem_q),
    .lane      (addr_r[1:0]),
    .funct3    (f3_r),
    .wdata     (wdata_r),
    .load_data (load_s),
    .merged    (merged_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (err_s) begin
            next_state_s = ST_RESP;
          end else if (req_we && (req_funct3 == F3_W)) begin
            next_state_s = ST_WR;
          end else begin
            next_state_s = ST_RD;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RD:   next_state_s = we_r ? ST_MOD : ST_CAP;
      ST_CAP:  next_state_s = ST_RESP;
      ST_MOD:  next_state_s = ST_WR;
      ST_WR:   next_state_s = ST_RESP;
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Word index comes from the live request at acceptance, else from the capture.
  always_comb begin
    if (state_r == ST_IDLE) begin
      word_idx_s = {2'b00, req_addr[31:2]};
    end else begin
      word_idx_s = {2'b00, addr_r[31:2]};
    end
  end

  // Request capture, memory-side and response registers, all aligned to next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_r       <= 1'b0;
      f3_r       <= 3'd0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
      mem_we_r   <= 1'b0;
      mem_addr   <= 32'd0;
      mem_data   <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      if (accept_s) begin
        we_r    <= req_we;
        f3_r    <= req_funct3;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      mem_we_r   <= (next_state_s == ST_WR);
      resp_valid <= (next_state_s == ST_RESP);
      if ((next_state_s == ST_RD) || (next_state_s == ST_WR)) begin
        mem_addr <= word_idx_s;
      end
      if ((state_r == ST_IDLE) && (next_state_s == ST_WR)) begin
        mem_data <= req_wdata;
      end else if (state_r == ST_MOD) begin
        mem_data <= merged_s;
      end
      if (accept_s) begin
        resp_err <= err_s;
      end else if (state_r == ST_RESP) begin
        resp_err <= 1'b0;
      end
      if (state_r == ST_CAP) begin
        resp_rdata <= load_s;
      end else if (state_r == ST_RESP) begin
        resp_rdata <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master with a behavioural
// synchronous-read word memory.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_data, mem_q;
  logic        mem_we;

  logic [31:0] mem_r [0:63];
  logic        tb_we;
  logic [5:0]  tb_waddr;
  logic [31:0] tb_wdata;

  int checks = 0;
  int failures = 0;
  int we_count = 0;
  int resp_count = 0;
  int snap_we, snap_resp;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_DEPTH(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_we     (mem_we),
    .mem_q      (mem_q)
  );

  always @(posedge clk) begin
    if (mem_we && (mem_addr < 32'd64)) mem_r[mem_addr[5:0]] <= mem_data;
    else if (tb_we) mem_r[tb_waddr] <= tb_wdata;
    mem_q <= (mem_addr < 32'd64) ? mem_r[mem_addr[5:0]] : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (mem_we) we_count++;
    if (resp_valid) resp_count++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    tb_we = 1'b1; tb_waddr = idx; tb_wdata = val;
    step;
    tb_we = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    step;
    req_valid = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
    do_req(1'b0, f3, addr, 32'd0);
    chk({tag, "_rd_addr"}, mem_addr, {2'b00, addr[31:2]});
    chk({tag, "_rd_we"}, {31'd0, mem_we}, 32'd0);
    step;
    chk({tag, "_n2_valid"}, {31'd0, resp_valid}, 32'd0);
    step;
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp);
    chk({tag, "_err"}, {31'd0, resp_err}, 32'd0);
    step;
    chk({tag, "_after_valid"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic err_chk(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr);
    do_req(we, f3, addr, 32'hFFFF_FFFF);
    chk({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, resp_err}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    step;
    chk({tag, "_err_clr"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; tb_we = 1'b0; tb_waddr = 6'd0; tb_wdata = 32'd0;
    step; step;
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_data", mem_data, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    step;
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    // SW to word 44
    do_req(1'b1, 3'd2, 32'h0000_00B0, 32'd35);
    chk("sw_addr", mem_addr, 32'd44);
    chk("sw_data", mem_data, 32'd35);
    chk("sw_we", {31'd0, mem_we}, 32'd1);
    chk("sw_n1_valid", {31'd0, resp_valid}, 32'd0);
    step;
    chk("sw_valid", {31'd0, resp_valid}, 32'd1);
    chk("sw_err", {31'd0, resp_err}, 32'd0);
    chk("sw_rdata", resp_rdata, 32'd0);
    chk("sw_we_once", {31'd0, mem_we}, 32'd0);
    step;
    chk("sw_valid_drop", {31'd0, resp_valid}, 32'd0);
    chk("sw_mem", mem_r[44], 32'd35);

    // Loads with extension
    preload(6'd16, 32'h80FF_7F01);
    load_chk("lb", 3'd0, 32'h43, 32'hFFFF_FF80);
    load_chk("lbu", 3'd4, 32'h43, 32'h0000_0080);
    load_chk("lb_pos", 3'd0, 32'h41, 32'h0000_007F);
    load_chk("lh", 3'd1, 32'h42, 32'hFFFF_80FF);
    load_chk("lhu", 3'd5, 32'h42, 32'h0000_80FF);
    load_chk("lh_lo", 3'd1, 32'h40, 32'h0000_7F01);
    load_chk("lw", 3'd2, 32'h40, 32'h80FF_7F01);

    // Sub-word stores (read-modify-write)
    preload(6'd16, 32'h1122_3344);
    do_req(1'b1, 3'd0, 32'h41, 32'h1234_56AB);
    step; step;
    chk("sb_we", {31'd0, mem_we}, 32'd1);
    chk("sb_data", mem_data, 32'h1122_AB44);
    chk("sb_addr", mem_addr, 32'd16);
    step;
    chk("sb_we_once", {31'd0, mem_we}, 32'd0);
    chk("sb_valid", {31'd0, resp_valid}, 32'd1);
    chk("sb_rdata", resp_rdata, 32'd0);
    step;
    chk("sb_mem", mem_r[16], 32'h1122_AB44);

    preload(6'd16, 32'h1122_3344);
    do_req(1'b1, 3'd1, 32'h42, 32'h0000_BEEF);
    step; step;
    chk("sh_we", {31'd0, mem_we}, 32'd1);
    chk("sh_data", mem_data, 32'hBEEF_3344);
    step;
    chk("sh_valid", {31'd0, resp_valid}, 32'd1);
    step;
    chk("sh_mem", mem_r[16], 32'hBEEF_3344);

    // Error requests: no memory activity
    snap_we = we_count;
    err_chk("lw_mis", 1'b0, 3'd2, 32'h42);
    err_chk("sw_oor", 1'b1, 3'd2, 32'h100);
    err_chk("ld_f3_3", 1'b0, 3'd3, 32'h0);
    err_chk("st_f3_4", 1'b1, 3'd4, 32'h0);
    err_chk("sh_mis", 1'b1, 3'd1, 32'h41);
    chk("err_no_we", we_count, snap_we);

    // Reset during the write cycle of a sub-word store
    preload(6'd16, 32'h1122_3344);
    snap_resp = resp_count;
    do_req(1'b1, 3'd0, 32'h41, 32'h0000_00AB);
    step; step;
    rst_n = 1'b0;
    #1;
    chk("rstwr_we_gated", {31'd0, mem_we}, 32'd0);
    chk("rstwr_ready", {31'd0, req_ready}, 32'd0);
    step;
    rst_n = 1'b1;
    #1;
    chk("rstwr_ready_rel", {31'd0, req_ready}, 32'd1);
    step;
    chk("rstwr_mem", mem_r[16], 32'h1122_3344);
    chk("rstwr_no_resp", resp_count, snap_resp);
    load_chk("rstwr_lw", 3'd2, 32'h40, 32'h1122_3344);

    // Back-to-back SW then LW with req_valid held
    snap_resp = resp_count;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0; req_wdata = 32'd99;
    step;
    chk("b2b_sw_we", {31'd0, mem_we}, 32'd1);
    req_we = 1'b0; req_wdata = 32'd0;
    step;
    chk("b2b_resp1", {31'd0, resp_valid}, 32'd1);
    chk("b2b_busy", {31'd0, req_ready}, 32'd0);
    step;
    chk("b2b_ready", {31'd0, req_ready}, 32'd1);
    chk("b2b_gap", {31'd0, resp_valid}, 32'd0);
    step;
    req_valid = 1'b0;
    chk("b2b_accepted", {31'd0, req_ready}, 32'd0);
    chk("b2b_rd_addr", mem_addr, 32'd0);
    step; step;
    chk("b2b_resp2", {31'd0, resp_valid}, 32'd1);
    chk("b2b_rdata", resp_rdata, 32'd99);
    step;
    chk("b2b_resp_count", resp_count - snap_resp, 32'd2);
    chk("b2b_idle", {31'd0, resp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Initiator side of the Data_Memory port (data/addr/we/clk/q); it sits between the RV32I execute stage and data memory.
- Accepts one load/store request at a time (funct3-encoded LB/LH/LW/LBU/LHU/SB/SH/SW) and converts byte addresses to word indices.
- Performs read-modify-write for sub-word stores, since memory has a single word-wide write enable.
- Sign/zero-extends load data and returns one response pulse per request.

Parameters:
- MEM_DEPTH, 64, number of 32-bit words in data memory; a word index >= MEM_DEPTH is an access error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE and with rst_n high; a request is accepted when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (load 0,1,2,4,5; store 0,1,2).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte/half is used for SB/SH.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal funct3, or out-of-range access; valid with resp_valid.
- mem_addr  out  32  word index = req_addr[31:2].
- mem_data  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_q  in  32  memory read data; synchronous read, valid one cycle after mem_addr is presented.

Behaviour:
- Reset: state IDLE; resp_valid, resp_err, mem_we, mem_addr, mem_data and resp_rdata all 0.
- req_ready is 0 while rst_n is low.
- mem_we is gated by rst_n, so no write can occur in a reset cycle even mid-operation.
- A reset in any state returns to IDLE on that edge. The pending request is dropped with no response.
- Request fields are registered at acceptance (cycle N). They are ignored outside acceptance.
- States: IDLE, RD, CAP, MOD, WR, RESP.
  - IDLE --accept--> RESP if the request is an error.
  - IDLE --accept--> WR if SW.
  - IDLE --accept--> RD otherwise.
  - RD -> CAP for loads, RD -> MOD for SB/SH.
  - CAP -> RESP.
  - MOD -> WR.
  - WR -> RESP.
  - RESP -> IDLE.
- Error conditions:
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]!=0.
  - funct3 of 3, 6 or 7 on a load.
  - funct3 > 2 on a store.
  - addr[31:2] >= MEM_DEPTH.
  - On error there is no memory activity (mem_we stays 0) and resp_err=1 in the RESP cycle.
- RD: mem_addr = word index, mem_we=0.
- CAP: select lane addr[1:0] (byte) or addr[1] (half) from mem_q. Sign-extend for funct3 0/1, zero-extend for 4/5. Register the result into resp_rdata.
- MOD: merge into a register.
  - SB replaces byte lane addr[1:0] of mem_q with wdata[7:0].
  - SH replaces half lane addr[1] with wdata[15:0].
  - The other lanes are preserved.
- WR: mem_addr = word index, mem_data = full word (SW) or merged word, mem_we=1 for exactly one cycle.
- RESP: resp_valid=1 for one cycle.
  - resp_rdata is extended data for a load, 0 otherwise.
  - resp_err and resp_rdata are cleared on return to IDLE.
- Latency from acceptance (cycle N) to resp_valid:
  - Load: N+3.
  - SW: N+2.
  - SB/SH: N+4.
  - Error: N+1.
- Back-to-back: the next accept is possible the cycle after RESP. There is no overlap.
- mem_addr and mem_data hold their last driven values outside RD/WR.
- Byte order is little-endian: byte 0 = bits [7:0].

Decomposition:
- Shared include/package riscv_lsu_defs: funct3 localparams (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5) and state encodings.
- One combinational sub-module, lsu_lane_align, is natural: load extraction/extension and store lane merge, both from (word, addr[1:0], funct3, wdata).
- The FSM stays in lsu_mem_master.

Test Plan:
1. SW addr=0xB0 (word 44), wdata=35 -> cycle N+1: mem_addr=44, mem_data=35, mem_we=1; N+2: resp_valid=1, resp_err=0.
2. Word 16 preloaded 0x80FF7F01, loads from 0x40:
   - LB 0x43 -> 0xFFFFFF80 at N+3.
   - LBU 0x43 -> 0x00000080.
   - LH 0x42 -> 0xFFFF80FF.
   - LHU 0x42 -> 0x000080FF.
   - LW 0x40 -> 0x80FF7F01.
3. Word 16 = 0x11223344:
   - SB 0x41, wdata=0xAB -> N+3 mem_data=0x1122AB44, mem_we=1 for one cycle.
   - SH 0x42, wdata=0xBEEF -> 0xBEEF3344.
4. Error cases:
   - LW 0x42 -> N+1 resp_err=1, resp_rdata=0, mem_we never 1.
   - SW to word 64 with MEM_DEPTH=64 -> resp_err=1.
5. Reset mid-operation: SB, then rst_n=0 in the WR cycle -> mem_we=0, memory word unchanged, no resp_valid; after release req_ready=1 and the next LW returns correct data.
6. Back-to-back against a behavioural synchronous-read memory: SW 0x00, 99 then LW 0x00 with req_valid held -> second accept the cycle after the first RESP; load returns 99, exactly one resp_valid per request.
